// File: rtl/param_processor_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : param_processor_core_if
//  Description : Instruction handshake and writeback bus of the
//                parametrised processor core. The master drives
//                instructions in; the slave (the core) returns results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface param_processor_core_if #(
  parameter int DATA_W = 16
);
  logic [15:0]       instruction;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic [2:0]        result_rd;
  logic [2:0]        flags;
  logic              illegal;

  modport master (
    output instruction, in_valid,
    input  in_ready, result, result_valid, result_rd, flags, illegal
  );

  modport slave (
    input  instruction, in_valid,
    output in_ready, result, result_valid, result_rd, flags, illegal
  );
endinterface
`default_nettype wire

// File: rtl/param_processor_core.sv
`default_nettype none
// ============================================================================
//  Module      : param_processor_core
//  Description : Two-stage (decode, execute/writeback) processor core with
//                configurable data width, 8-entry register file, Z/N/C
//                flags and an iterative shift-add multiplier that stalls
//                the instruction handshake while it runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_processor_core #(
  parameter int DATA_W   = 16,
  parameter bit RF_RESET = 1'b1
) (
  input wire                    clk,
  input wire                    rst,
  param_processor_core_if.slave bus_io
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int DW1   = DATA_W + 1;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_ADC = 4'hA;
  localparam logic [3:0] OP_MUL = 4'hB;

  typedef enum logic [0:0] {
    ST_EXE = 1'b0,
    ST_MUL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                s1_valid_q, s1_valid_d;
  logic [15:0]         s1_instr_q, s1_instr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [2:0]          mul_rd_q, mul_rd_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [2:0]          result_rd_q, result_rd_d;
  logic                result_valid_q, result_valid_d;
  logic [2:0]          flags_q, flags_d;
  logic                illegal_q, illegal_d;
  logic [DATA_W-1:0]   rf_q [8];

  // Decode fields and register-file read ports
  logic [3:0]          w_op;
  logic [2:0]          w_rs1, w_rs2, w_rd;
  logic [5:0]          w_imm;
  logic [DATA_W-1:0]   w_a, w_b;
  logic [SH_W-1:0]     w_shamt;
  logic [DATA_W-1:0]   w_alu_res;
  logic                w_alu_c;
  logic [2*DATA_W-1:0] w_mul_sum;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_wr_en;
  logic [2:0]          w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;
  logic                w_unused_bits;

  assign w_op    = s1_instr_q[15:12];
  assign w_rs1   = s1_instr_q[11:9];
  assign w_rs2   = s1_instr_q[8:6];
  assign w_rd    = s1_instr_q[5:3];
  assign w_imm   = s1_instr_q[11:6];
  assign w_a     = rf_q[w_rs1];
  assign w_b     = rf_q[w_rs2];
  assign w_shamt = w_b[SH_W-1:0];
  assign w_unused_bits = ^s1_instr_q[2:0];

  // A MUL sitting in decode, or a MUL in flight, blocks new instructions
  assign w_in_ready = (state_q == ST_EXE) && !(s1_valid_q && (w_op == OP_MUL));
  assign w_accept   = bus_io.in_valid && w_in_ready;

  // One multiplier iteration: add shifted multiplicand when multiplier LSB set
  assign w_mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle ALU: result plus the op-specific carry/borrow/shift-out bit
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    case (w_op)
      OP_ADD: {w_alu_c, w_alu_res} = {1'b0, w_a} + {1'b0, w_b};
      OP_ADC: {w_alu_c, w_alu_res} = {1'b0, w_a} + {1'b0, w_b} + DW1'(flags_q[0]);
      OP_SUB: {w_alu_c, w_alu_res} = {1'b0, w_a} - {1'b0, w_b};
      OP_AND: w_alu_res = w_a & w_b;
      OP_OR:  w_alu_res = w_a | w_b;
      OP_XOR: w_alu_res = w_a ^ w_b;
      OP_NOT: w_alu_res = ~w_a;
      OP_LDI: w_alu_res = DATA_W'(w_imm);
      // Extra bit above/below the operand catches the last bit shifted out;
      // a zero shift leaves it 0.
      OP_SHL: {w_alu_c, w_alu_res} = {1'b0, w_a} << w_shamt;
      OP_SHR: {w_alu_res, w_alu_c} = {w_a, 1'b0} >> w_shamt;
      default: ;
    endcase
  end

  // Execute FSM next state, writeback, flags and decode-stage bookkeeping
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    acc_d          = acc_q;
    mul_rd_d       = mul_rd_q;
    result_d       = result_q;
    result_rd_d    = result_rd_q;
    result_valid_d = 1'b0;
    flags_d        = flags_q;
    illegal_d      = 1'b0;
    w_wr_en        = 1'b0;
    w_wr_addr      = w_rd;
    w_wr_data      = w_alu_res;
    s1_instr_d     = w_accept ? bus_io.instruction : s1_instr_q;
    // Whatever sits in decode is consumed by the next EXE edge
    s1_valid_d     = w_accept ? 1'b1 : ((state_q == ST_EXE) ? 1'b0 : s1_valid_q);

    case (state_q)
      ST_EXE: begin
        if (s1_valid_q) begin
          if (w_op == OP_NOP) begin
            // retires silently
          end else if (w_op == OP_MUL) begin
            state_d  = ST_MUL;
            mcand_d  = {{DATA_W{1'b0}}, w_a};
            mplier_d = w_b;
            acc_d    = '0;
            cnt_d    = CNT_W'(DATA_W);
            mul_rd_d = w_rd;
          end else if (w_op[3:2] == 2'b11) begin
            illegal_d = 1'b1;
          end else begin
            w_wr_en        = 1'b1;
            result_d       = w_alu_res;
            result_rd_d    = w_rd;
            result_valid_d = 1'b1;
            flags_d        = {(w_alu_res == '0), w_alu_res[DATA_W-1], w_alu_c};
          end
        end
      end
      ST_MUL: begin
        acc_d    = w_mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d        = ST_EXE;
          w_wr_en        = 1'b1;
          w_wr_addr      = mul_rd_q;
          w_wr_data      = w_mul_sum[DATA_W-1:0];
          result_d       = w_mul_sum[DATA_W-1:0];
          result_rd_d    = mul_rd_q;
          result_valid_d = 1'b1;
          flags_d        = {(w_mul_sum[DATA_W-1:0] == '0),
                            w_mul_sum[DATA_W-1],
                            |w_mul_sum[2*DATA_W-1:DATA_W]};
        end
      end
      default: state_d = ST_EXE;
    endcase
  end

  // Control state and registered outputs; reset aborts any multiply
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_EXE;
      s1_valid_q     <= 1'b0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_rd_q    <= '0;
      result_valid_q <= 1'b0;
      flags_q        <= '0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      s1_valid_q     <= s1_valid_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_rd_q    <= result_rd_d;
      result_valid_q <= result_valid_d;
      flags_q        <= flags_d;
      illegal_q      <= illegal_d;
    end
  end

  // Datapath registers need no reset; they are qualified by the control state
  always_ff @(posedge clk) begin
    s1_instr_q <= s1_instr_d;
    mcand_q    <= mcand_d;
    mplier_q   <= mplier_d;
    acc_q      <= acc_d;
    mul_rd_q   <= mul_rd_d;
  end

  if (RF_RESET) begin : g_rf_reset
    // Register file write port, cleared by reset
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      end else if (w_wr_en) begin
        rf_q[w_wr_addr] <= w_wr_data;
      end
    end
  end else begin : g_rf_keep
    // Register file write port, contents survive reset
    always_ff @(posedge clk) begin
      if (!rst && w_wr_en) begin
        rf_q[w_wr_addr] <= w_wr_data;
      end
    end
  end

  assign bus_io.in_ready     = w_in_ready;
  assign bus_io.result       = result_q;
  assign bus_io.result_rd    = result_rd_q;
  assign bus_io.result_valid = result_valid_q;
  assign bus_io.flags        = flags_q;
  assign bus_io.illegal      = illegal_q;

endmodule
`default_nettype wire
